// File: rtl/am2940_pkg.sv
// Shared opcodes, word-count modes and state encoding for the Am2940-style DMA
// control stage.
package am2940_pkg;

    localparam logic [2:0] OP_WRCR   = 3'd0;
    localparam logic [2:0] OP_RDCR   = 3'd1;
    localparam logic [2:0] OP_RDWC   = 3'd2;
    localparam logic [2:0] OP_RDAC   = 3'd3;
    localparam logic [2:0] OP_REINIT = 3'd4;
    localparam logic [2:0] OP_LDAR   = 3'd5;
    localparam logic [2:0] OP_LDWR   = 3'd6;
    localparam logic [2:0] OP_ENABLE = 3'd7;

    typedef enum logic [1:0] {
        MODE_DEC      = 2'b00,
        MODE_INC_CMP  = 2'b01,
        MODE_ADDR_CMP = 2'b10,
        MODE_INC_FREE = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/am2940_ctrl_if.sv
// Bus between the control stage, its host (instruction/read-back side) and the
// two counter-slice chains.
interface am2940_ctrl_if #(parameter int W = 8);

    logic         instr_valid;
    logic [2:0]   instr;
    logic [W-1:0] data_in;
    logic         cnt_strobe;
    logic [W-1:0] addr_count;
    logic [W-1:0] wc_count;
    logic         addr_load;
    logic         wc_load;
    logic [W-1:0] addr_data;
    logic [W-1:0] wc_data;
    logic         addr_en;
    logic         wc_en;
    logic         addr_up;
    logic         wc_up;
    logic [W-1:0] data_out;
    logic         data_oe;
    logic         done;

    modport master (
        output instr_valid, instr, data_in, cnt_strobe, addr_count, wc_count,
        input  addr_load, wc_load, addr_data, wc_data, addr_en, wc_en,
               addr_up, wc_up, data_out, data_oe, done
    );

    modport slave (
        input  instr_valid, instr, data_in, cnt_strobe, addr_count, wc_count,
        output addr_load, wc_load, addr_data, wc_data, addr_en, wc_en,
               addr_up, wc_up, data_out, data_oe, done
    );

endinterface

// File: rtl/am2940_done_detect.sv
// Combinational terminal-count compare; shared between the FSM and any status
// path that needs the same view of "transfer finished".
module am2940_done_detect
    import am2940_pkg::*;
#(
    parameter int W = 8
) (
    input  mode_t        mode,
    input  logic [W-1:0] wc_count,
    input  logic [W-1:0] addr_count,
    input  logic [W-1:0] word_reg,
    output logic         done_cond
);

    always_comb begin
        done_cond = 1'b0;
        unique case (mode)
            MODE_DEC:      done_cond = (wc_count == '0);
            MODE_INC_CMP:  done_cond = (wc_count == word_reg);
            MODE_ADDR_CMP: done_cond = (addr_count == word_reg);
            MODE_INC_FREE: done_cond = 1'b0;
            default:       done_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/am2940_ctrl.sv
// Instruction decode, control/address/word registers and run/done sequencing
// for the Am2940-style DMA generator; drives both counter-slice chains.
module am2940_ctrl
    import am2940_pkg::*;
#(
    parameter int W = 8
) (
    input logic          clk,
    input logic          res_n,
    am2940_ctrl_if.slave bus
);

    logic [2:0]   cr;
    logic [W-1:0] addr_reg;
    logic [W-1:0] word_reg;
    state_t       state;
    mode_t        mode;
    logic         done_cond;
    logic         step;

    assign mode = mode_t'(cr[1:0]);

    am2940_done_detect #(.W(W)) u_done_detect (
        .mode       (mode),
        .wc_count   (bus.wc_count),
        .addr_count (bus.addr_count),
        .word_reg   (word_reg),
        .done_cond  (done_cond)
    );

    // A step is suppressed by any instruction, a pending load or a reached
    // terminal count; it is also masked during reset so the chains hold.
    always_comb begin
        step = res_n && (state == ST_RUN) && bus.cnt_strobe && !done_cond
               && !bus.instr_valid && !bus.addr_load && !bus.wc_load;
    end

    assign bus.addr_en = step;
    assign bus.wc_en   = step && (mode != MODE_ADDR_CMP);
    assign bus.addr_up = ~cr[2];
    assign bus.wc_up   = (mode != MODE_DEC);
    assign bus.done    = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!res_n) begin
            cr            <= '0;
            addr_reg      <= '0;
            word_reg      <= '0;
            state         <= ST_IDLE;
            bus.addr_load <= 1'b0;
            bus.wc_load   <= 1'b0;
            bus.addr_data <= '0;
            bus.wc_data   <= '0;
            bus.data_out  <= '0;
            bus.data_oe   <= 1'b0;
        end else begin
            bus.addr_load <= 1'b0;
            bus.wc_load   <= 1'b0;
            bus.data_oe   <= 1'b0;
            if (state == ST_RUN && done_cond) begin
                state <= ST_DONE;
            end
            if (bus.instr_valid) begin
                case (bus.instr)
                    OP_WRCR: begin
                        cr    <= bus.data_in[2:0];
                        state <= ST_IDLE;
                    end
                    OP_RDCR: begin
                        bus.data_out <= {{(W-3){1'b0}}, cr};
                        bus.data_oe  <= 1'b1;
                    end
                    OP_RDWC: begin
                        bus.data_out <= bus.wc_count;
                        bus.data_oe  <= 1'b1;
                    end
                    OP_RDAC: begin
                        bus.data_out <= bus.addr_count;
                        bus.data_oe  <= 1'b1;
                    end
                    OP_REINIT: begin
                        bus.addr_load <= 1'b1;
                        bus.addr_data <= addr_reg;
                        if (mode != MODE_ADDR_CMP) begin
                            bus.wc_load <= 1'b1;
                            bus.wc_data <= (mode == MODE_DEC) ? word_reg : '0;
                        end
                        state <= ST_IDLE;
                    end
                    OP_LDAR: begin
                        addr_reg      <= bus.data_in;
                        bus.addr_load <= 1'b1;
                        bus.addr_data <= bus.data_in;
                        state         <= ST_IDLE;
                    end
                    OP_LDWR: begin
                        word_reg <= bus.data_in;
                        if (mode != MODE_ADDR_CMP) begin
                            bus.wc_load <= 1'b1;
                            bus.wc_data <= (mode == MODE_DEC) ? bus.data_in : '0;
                        end
                        state <= ST_IDLE;
                    end
                    OP_ENABLE: begin
                        if (state != ST_RUN) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_am2940_ctrl.sv
// Directed bench for am2940_ctrl: behavioural counter chains plus hand-computed
// expectations for each instruction and counting mode.
module tb_am2940_ctrl;
    import am2940_pkg::*;

    logic clk;
    logic res_n;
    int   vectors;
    int   miscompares;

    am2940_ctrl_if #(.W(8)) bus ();

    am2940_ctrl #(.W(8)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural stand-ins for the two cascaded slice chains.
    logic [7:0] addr_chain = 8'h00;
    logic [7:0] wc_chain   = 8'h00;
    assign bus.addr_count = addr_chain;
    assign bus.wc_count   = wc_chain;

    always @(posedge clk) begin
        if (bus.addr_load)
            addr_chain <= bus.addr_data;
        else if (bus.addr_en)
            addr_chain <= bus.addr_up ? addr_chain + 8'd1 : addr_chain - 8'd1;
        if (bus.wc_load)
            wc_chain <= bus.wc_data;
        else if (bus.wc_en)
            wc_chain <= bus.wc_up ? wc_chain + 8'd1 : wc_chain - 8'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge, where the
    // registered response to the instruction is visible.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] d);
        bus.instr_valid = 1'b1;
        bus.instr       = op;
        bus.data_in     = d;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.data_in     = 8'h00;
    endtask

    task automatic runStrobes(input int n, output int a_en, output int w_en);
        a_en = 0;
        w_en = 0;
        for (int i = 0; i < n; i++) begin
            bus.cnt_strobe = 1'b1;
            #1;
            if (bus.addr_en) a_en++;
            if (bus.wc_en)   w_en++;
            @(negedge clk);
        end
        bus.cnt_strobe = 1'b0;
    endtask

    initial begin
        int a_cnt;
        int w_cnt;
        logic done_seen;
        logic wrapped;
        logic [7:0] prev_wc;

        vectors        = 0;
        miscompares    = 0;
        res_n          = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr      = 3'd0;
        bus.data_in    = 8'h00;
        bus.cnt_strobe = 1'b0;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_oe", bus.data_oe, 0);
        checkOutput("rst_aload", bus.addr_load, 0);
        checkOutput("rst_wload", bus.wc_load, 0);
        checkOutput("rst_dout", bus.data_out, 0);

        // Mode 00: count down from 3
        applyStimulus(OP_WRCR, 8'h00);
        applyStimulus(OP_LDAR, 8'h10);
        checkOutput("m0_aload", bus.addr_load, 1);
        checkOutput("m0_adata", bus.addr_data, 8'h10);
        applyStimulus(OP_LDWR, 8'd3);
        checkOutput("m0_wload", bus.wc_load, 1);
        checkOutput("m0_wdata", bus.wc_data, 8'd3);
        applyStimulus(OP_ENABLE, 8'h00);
        checkOutput("m0_aup", bus.addr_up, 1);
        checkOutput("m0_wup", bus.wc_up, 0);
        runStrobes(6, a_cnt, w_cnt);
        checkOutput("m0_aen_cnt", a_cnt, 3);
        checkOutput("m0_wen_cnt", w_cnt, 3);
        checkOutput("m0_addr", addr_chain, 8'h13);
        checkOutput("m0_wc", wc_chain, 8'h00);
        checkOutput("m0_done", bus.done, 1);
        applyStimulus(OP_RDAC, 8'h00);
        checkOutput("m0_rdac", bus.data_out, 8'h13);
        checkOutput("m0_rdac_oe", bus.data_oe, 1);
        applyStimulus(OP_RDCR, 8'h00);
        checkOutput("m0_rdcr", bus.data_out, 8'h00);
        checkOutput("m0_done_hold", bus.done, 1);

        // Mode 10 with decrementing address
        applyStimulus(OP_WRCR, 8'h06);
        checkOutput("m2_idle", bus.done, 0);
        applyStimulus(OP_LDAR, 8'h05);
        checkOutput("m2_adata", bus.addr_data, 8'h05);
        applyStimulus(OP_LDWR, 8'h02);
        checkOutput("m2_no_wload", bus.wc_load, 0);
        applyStimulus(OP_ENABLE, 8'h00);
        checkOutput("m2_aup", bus.addr_up, 0);
        checkOutput("m2_wup", bus.wc_up, 1);
        runStrobes(6, a_cnt, w_cnt);
        checkOutput("m2_aen_cnt", a_cnt, 3);
        checkOutput("m2_wen_cnt", w_cnt, 0);
        checkOutput("m2_addr", addr_chain, 8'h02);
        checkOutput("m2_done", bus.done, 1);

        // Instruction beats a simultaneous strobe
        applyStimulus(OP_WRCR, 8'h01);
        applyStimulus(OP_LDAR, 8'h20);
        applyStimulus(OP_LDWR, 8'd4);
        checkOutput("m1_wload", bus.wc_load, 1);
        checkOutput("m1_wdata", bus.wc_data, 8'h00);
        applyStimulus(OP_ENABLE, 8'h00);
        runStrobes(1, a_cnt, w_cnt);
        checkOutput("m1_first_step", a_cnt, 1);
        bus.cnt_strobe  = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = OP_RDAC;
        #1;
        checkOutput("prio_no_en", bus.addr_en, 0);
        @(negedge clk);
        bus.cnt_strobe  = 1'b0;
        bus.instr_valid = 1'b0;
        checkOutput("prio_dout", bus.data_out, 8'h21);
        checkOutput("prio_oe", bus.data_oe, 1);
        checkOutput("prio_addr_held", addr_chain, 8'h21);
        @(negedge clk);
        checkOutput("prio_oe_pulse", bus.data_oe, 0);
        runStrobes(6, a_cnt, w_cnt);
        checkOutput("m1_aen_cnt", a_cnt, 3);
        checkOutput("m1_addr", addr_chain, 8'h24);
        checkOutput("m1_wc", wc_chain, 8'h04);
        checkOutput("m1_done", bus.done, 1);

        // Abort mid-RUN and re-arm from the registers
        applyStimulus(OP_WRCR, 8'h00);
        applyStimulus(OP_LDAR, 8'h40);
        applyStimulus(OP_LDWR, 8'd8);
        applyStimulus(OP_ENABLE, 8'h00);
        runStrobes(2, a_cnt, w_cnt);
        checkOutput("ab_steps", a_cnt, 2);
        checkOutput("ab_addr", addr_chain, 8'h42);
        applyStimulus(OP_LDWR, 8'd5);
        checkOutput("ab_wload", bus.wc_load, 1);
        checkOutput("ab_wdata", bus.wc_data, 8'd5);
        runStrobes(2, a_cnt, w_cnt);
        checkOutput("ab_idle_no_en", a_cnt, 0);
        checkOutput("ab_wc", wc_chain, 8'd5);
        applyStimulus(OP_REINIT, 8'h00);
        checkOutput("ri_aload", bus.addr_load, 1);
        checkOutput("ri_adata", bus.addr_data, 8'h40);
        checkOutput("ri_wload", bus.wc_load, 1);
        checkOutput("ri_wdata", bus.wc_data, 8'd5);
        @(negedge clk);
        applyStimulus(OP_RDAC, 8'h00);
        checkOutput("ri_rdac", bus.data_out, 8'h40);
        applyStimulus(OP_RDWC, 8'h00);
        checkOutput("ri_rdwc", bus.data_out, 8'h05);

        // Mode 11 free run through a wrap
        applyStimulus(OP_WRCR, 8'h03);
        applyStimulus(OP_LDAR, 8'h00);
        applyStimulus(OP_LDWR, 8'h00);
        applyStimulus(OP_ENABLE, 8'h00);
        done_seen = 1'b0;
        wrapped   = 1'b0;
        a_cnt     = 0;
        for (int i = 0; i < 300; i++) begin
            bus.cnt_strobe = 1'b1;
            #1;
            if (bus.addr_en) a_cnt++;
            if (bus.done) done_seen = 1'b1;
            prev_wc = wc_chain;
            @(negedge clk);
            if (prev_wc == 8'hFF && wc_chain == 8'h00) wrapped = 1'b1;
        end
        checkOutput("m3_steps", a_cnt, 300);
        checkOutput("m3_no_done", done_seen, 0);
        checkOutput("m3_wrapped", wrapped, 1);
        checkOutput("m3_wc", wc_chain, 8'h2C);
        checkOutput("m3_addr", addr_chain, 8'h2C);

        // Reset while running with the strobe still asserted
        res_n = 1'b0;
        #1;
        checkOutput("rr_en_masked", bus.addr_en, 0);
        repeat (2) @(negedge clk);
        res_n          = 1'b1;
        bus.cnt_strobe = 1'b0;
        checkOutput("rr_done", bus.done, 0);
        checkOutput("rr_oe", bus.data_oe, 0);
        applyStimulus(OP_RDCR, 8'h00);
        checkOutput("rr_cr", bus.data_out, 8'h00);
        checkOutput("rr_cr_oe", bus.data_oe, 1);
        bus.cnt_strobe = 1'b1;
        #1;
        checkOutput("rr_idle_no_en", bus.addr_en, 0);
        bus.cnt_strobe = 1'b0;

        // A load issued on the reset edge leaves no pulse
        res_n           = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = OP_LDAR;
        bus.data_in     = 8'h77;
        @(negedge clk);
        res_n           = 1'b1;
        bus.instr_valid = 1'b0;
        checkOutput("rl_no_aload", bus.addr_load, 0);
        checkOutput("rl_adata", bus.addr_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
